// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB register responder.
package sccb_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_DEV     = 4'd1,
        ST_DEV_ACK = 4'd2,
        ST_SUB     = 4'd3,
        ST_SUB_ACK = 4'd4,
        ST_WDATA   = 4'd5,
        ST_WACK    = 4'd6,
        ST_RDATA   = 4'd7,
        ST_RACK    = 4'd8,
        ST_IGNORE  = 4'd9
    } sccb_state_e;

    localparam logic [7:0] SCCB_DEF_DEV_ADDR = 8'h42;

    // Values of the open-drain output enable: asserted means SDA is pulled low.
    localparam logic SDA_DRIVE_LOW = 1'b1;
    localparam logic SDA_RELEASE   = 1'b0;

endpackage

// File: rtl/sccb_line_sync.sv
// Two-flop synchronisers for SCL/SDA plus edge and START/STOP detection.
module sccb_line_sync (
    input  logic iCLK,
    input  logic iRST_N,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [1:0] scl_sync_q;
    logic [1:0] sda_sync_q;
    logic       scl_prev_q;
    logic       sda_prev_q;
    logic       scl_s;

    // Reset to the idle-bus level so leaving reset never fakes an edge.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            scl_prev_q <= scl_sync_q[1];
            sda_prev_q <= sda_sync_q[1];
        end
    end

    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/sccb_reg_responder.sv
// SCCB target: ACKs DEV_ADDR writes and commits data bytes into a 256x8 array.
// Optional read-back path enabled with `define SCCB_REG_RESPONDER_READ_EN.
module sccb_reg_responder
    import sccb_pkg::*;
#(
    parameter logic [7:0] DEV_ADDR = SCCB_DEF_DEV_ADDR
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        I2C_SCLK,
    inout  wire         I2C_SDAT,
    input  logic [7:0]  iRD_ADDR,
    output logic [7:0]  oRD_DATA,
    output logic        oWR_STB,
    output logic [7:0]  oWR_ADDR,
    output logic [7:0]  oWR_DATA,
    output logic [15:0] oWR_CNT,
    output logic        oBUSY,
    output logic [3:0]  oSTATE
);

    logic scl_rise, scl_fall, start_det, stop_det, sda_s;

    sccb_line_sync u_sync (
        .iCLK      (iCLK),
        .iRST_N    (iRST_N),
        .scl_i     (I2C_SCLK),
        .sda_i     (I2C_SDAT),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    sccb_state_e state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        byte_done_q, byte_done_d;
    logic [7:0]  ptr_q, ptr_d;
    logic        sda_oe_q, sda_oe_d;
    logic        busy_q, busy_d;
    logic        stb_q, stb_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic [15:0] cnt_q, cnt_d;
    logic        mem_we;
    logic [7:0]  mem_q [256];
    logic [7:0]  rd_data_q;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            byte_done_q <= 1'b0;
            ptr_q       <= 8'h00;
            sda_oe_q    <= SDA_RELEASE;
            busy_q      <= 1'b0;
            stb_q       <= 1'b0;
            wr_addr_q   <= 8'h00;
            wr_data_q   <= 8'h00;
            cnt_q       <= 16'h0000;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            byte_done_q <= byte_done_d;
            ptr_q       <= ptr_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            stb_q       <= stb_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        byte_done_d = byte_done_q;
        ptr_d       = ptr_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        stb_d       = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        cnt_d       = cnt_q;
        mem_we      = 1'b0;

        if (start_det) begin
            state_d     = ST_DEV;
            bit_cnt_d   = 3'd0;
            byte_done_d = 1'b0;
            sda_oe_d    = SDA_RELEASE;
            busy_d      = 1'b1;
        end else if (stop_det) begin
            state_d     = ST_IDLE;
            bit_cnt_d   = 3'd0;
            byte_done_d = 1'b0;
            sda_oe_d    = SDA_RELEASE;
            busy_d      = 1'b0;
        end else begin
            case (state_q)
                ST_DEV, ST_SUB, ST_WDATA: begin
                    // Bytes complete on the 8th rise; the decision waits for the next fall.
                    if (scl_rise && !byte_done_q) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) byte_done_d = 1'b1;
                    end else if (scl_fall && byte_done_q) begin
                        byte_done_d = 1'b0;
                        bit_cnt_d   = 3'd0;
                        case (state_q)
                            ST_DEV: begin
                                if (shift_q == DEV_ADDR) begin
                                    state_d  = ST_DEV_ACK;
                                    sda_oe_d = SDA_DRIVE_LOW;
                                end
`ifdef SCCB_REG_RESPONDER_READ_EN
                                else if (shift_q == (DEV_ADDR | 8'h01)) begin
                                    state_d  = ST_DEV_ACK;
                                    sda_oe_d = SDA_DRIVE_LOW;
                                end
`endif
                                else begin
                                    state_d = ST_IGNORE;
                                end
                            end
                            ST_SUB: begin
                                state_d  = ST_SUB_ACK;
                                sda_oe_d = SDA_DRIVE_LOW;
                                ptr_d    = shift_q;
                            end
                            default: begin
                                state_d   = ST_WACK;
                                sda_oe_d  = SDA_DRIVE_LOW;
                                stb_d     = 1'b1;
                                mem_we    = 1'b1;
                                wr_addr_d = ptr_q;
                                wr_data_d = shift_q;
                                cnt_d     = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                                ptr_d     = ptr_q + 8'd1;
                            end
                        endcase
                    end
                end
                ST_DEV_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = SDA_RELEASE;
                        state_d  = ST_SUB;
`ifdef SCCB_REG_RESPONDER_READ_EN
                        // shift_q still holds the address byte; its LSB selects read.
                        if (shift_q[0]) begin
                            state_d   = ST_RDATA;
                            shift_d   = mem_q[ptr_q];
                            sda_oe_d  = ~mem_q[ptr_q][7];
                            bit_cnt_d = 3'd0;
                        end
`endif
                    end
                end
                ST_SUB_ACK, ST_WACK: begin
                    if (scl_fall) begin
                        sda_oe_d = SDA_RELEASE;
                        state_d  = ST_WDATA;
                    end
                end
`ifdef SCCB_REG_RESPONDER_READ_EN
                ST_RDATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd7) begin
                            sda_oe_d    = SDA_RELEASE;
                            state_d     = ST_RACK;
                            byte_done_d = 1'b0;
                        end else begin
                            shift_d   = {shift_q[6:0], 1'b0};
                            sda_oe_d  = ~shift_q[6];
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                ST_RACK: begin
                    if (scl_rise) begin
                        if (!sda_s) byte_done_d = 1'b1;
                        else        state_d     = ST_IGNORE;
                    end else if (scl_fall && byte_done_q) begin
                        ptr_d       = ptr_q + 8'd1;
                        shift_d     = mem_q[ptr_q + 8'd1];
                        sda_oe_d    = ~mem_q[ptr_q + 8'd1][7];
                        bit_cnt_d   = 3'd0;
                        byte_done_d = 1'b0;
                        state_d     = ST_RDATA;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Register array; a same-cycle read of the written address sees the old value.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 0; i < 256; i++) mem_q[i] <= 8'h00;
            rd_data_q <= 8'h00;
        end else begin
            if (mem_we) mem_q[ptr_q] <= shift_q;
            rd_data_q <= mem_q[iRD_ADDR];
        end
    end

    assign I2C_SDAT = (sda_oe_q == SDA_DRIVE_LOW) ? 1'b0 : 1'bz;
    assign oRD_DATA = rd_data_q;
    assign oWR_STB  = stb_q;
    assign oWR_ADDR = wr_addr_q;
    assign oWR_DATA = wr_data_q;
    assign oWR_CNT  = cnt_q;
    assign oBUSY    = busy_q;
    assign oSTATE   = state_q;

endmodule
